joypad_events: RTL and testbench

Downstream consumer of the NES controller bridge: accepts the bridge's `joypad`/`joypad_valid` samples, debounces them, turns accepted changes into press/release events queued in a small FIFO, and exposes state, events and status to the RISC-V core as a 4-register memory-mapped peripheral with a level interrupt. It runs in the bridge's clock domain (the 50 MHz `clk_half` net), so no CDC is needed.

---
 rtl/joypad_pkg.sv | 37 +++
 rtl/joypad_events_if.sv | 24 ++
 rtl/joypad_events_sync_fifo.sv | 52 +++++
 rtl/joypad_events.sv | 129 ++++++++++++
 tb/tb_joypad_events.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/joypad_pkg.sv
// Shared constants for the joypad event peripheral: register map, STATUS/EVENT bit layout
// and the packed press/release event record.
package joypad_pkg;

  localparam int unsigned JP_BTN_W   = 8;
  localparam int unsigned JP_DATA_W  = 32;
  localparam int unsigned JP_ADDR_W  = 4;

  // Byte offsets of the four registers
  localparam logic [JP_ADDR_W-1:0] JP_STATE  = 4'h0;
  localparam logic [JP_ADDR_W-1:0] JP_EVENT  = 4'h4;
  localparam logic [JP_ADDR_W-1:0] JP_STATUS = 4'h8;
  localparam logic [JP_ADDR_W-1:0] JP_CTRL   = 4'hC;

  localparam int unsigned ST_COUNT_W   = 7;
  localparam int unsigned ST_EMPTY_BIT = 8;
  localparam int unsigned ST_FULL_BIT  = 9;
  localparam int unsigned ST_OVF_BIT   = 16;
  localparam int unsigned EV_VALID_BIT = 31;
  localparam int unsigned CTRL_IEN_BIT = 0;

  typedef struct packed {
    logic [JP_BTN_W-1:0] released;
    logic [JP_BTN_W-1:0] pressed;
  } jp_event_t;

  localparam int unsigned JP_EVENT_W = $bits(jp_event_t);

  function automatic jp_event_t jp_make_event(input logic [JP_BTN_W-1:0] old_s,
                                              input logic [JP_BTN_W-1:0] new_s);
    jp_event_t ev;
    ev.released = old_s & ~new_s;
    ev.pressed  = new_s & ~old_s;
    return ev;
  endfunction

endpackage

// File: rtl/joypad_events_if.sv
// Controller sample input plus the register bus and interrupt of the joypad event peripheral.
interface joypad_events_if;
  import joypad_pkg::*;

  logic                 joypad_valid;
  logic [JP_BTN_W-1:0]  joypad;
  logic                 sel;
  logic                 we;
  logic [JP_ADDR_W-1:0] addr;
  logic [JP_DATA_W-1:0] wdata;
  logic [JP_DATA_W-1:0] rdata;
  logic                 irq;

  modport master (
    output joypad_valid, joypad, sel, we, addr, wdata,
    input  rdata, irq
  );

  modport slave (
    input  joypad_valid, joypad, sel, we, addr, wdata,
    output rdata, irq
  );

endinterface

// File: rtl/joypad_events_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset; a pop on empty is ignored and a push
// while full only lands when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/joypad_events.sv
// Debounces controller samples, queues press/release events and exposes state, events,
// status and an interrupt enable through four memory-mapped registers.
module joypad_events
  import joypad_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = 3,
  parameter int unsigned DEPTH        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  joypad_events_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(STABLE_COUNT + 1);
  localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;

  logic [JP_BTN_W-1:0]  cand_q, cand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [JP_BTN_W-1:0]  state_q;
  logic                 ovf_q;
  logic                 ien_q;
  logic                 irq_q;

  logic                 accept;
  logic                 push_ev;
  jp_event_t            new_ev;
  logic [1:0]           reg_idx;
  logic                 rd_event;
  logic                 wr_status;
  logic                 wr_ctrl;
  logic                 ovf_set;

  logic [JP_EVENT_W-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCNT_W-1:0]     fifo_count;
  logic [JP_DATA_W-1:0]  rdata_c;

  // Candidate tracking: a new value restarts the run, a repeat counts up to saturation
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (bus.joypad_valid) begin
      if (bus.joypad == cand_q) begin
        if (cnt_q != CNT_W'(STABLE_COUNT)) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cand_d = bus.joypad;
        cnt_d  = CNT_W'(1);
      end
    end
  end

  assign accept  = bus.joypad_valid && (cnt_d == CNT_W'(STABLE_COUNT));
  assign push_ev = accept && (bus.joypad != state_q);
  assign new_ev  = jp_make_event(state_q, bus.joypad);

  assign reg_idx   = bus.addr[3:2];
  assign rd_event  = bus.sel & ~bus.we & (reg_idx == JP_EVENT[3:2]);
  assign wr_status = bus.sel &  bus.we & (reg_idx == JP_STATUS[3:2]);
  assign wr_ctrl   = bus.sel &  bus.we & (reg_idx == JP_CTRL[3:2]);
  // A simultaneous pop frees the slot, so only an unpaired push into a full FIFO is lost
  assign ovf_set   = push_ev & fifo_full & ~rd_event;

  sync_fifo #(
    .WIDTH (JP_EVENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ev),
    .din   (new_ev),
    .pop   (rd_event),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q  <= '0;
      cnt_q   <= '0;
      state_q <= '0;
      ovf_q   <= 1'b0;
      ien_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      if (push_ev) state_q <= bus.joypad;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (wr_status && bus.wdata[ST_OVF_BIT]) begin
        ovf_q <= 1'b0;
      end
      if (wr_ctrl) ien_q <= bus.wdata[CTRL_IEN_BIT];
      irq_q <= ien_q & ~fifo_empty;
    end
  end

  // Read mux; the EVENT word shows the FIFO head only when something is queued
  always_comb begin
    rdata_c = '0;
    case (reg_idx)
      JP_STATE[3:2]:  rdata_c[JP_BTN_W-1:0] = state_q;
      JP_EVENT[3:2]: begin
        if (!fifo_empty) begin
          rdata_c[JP_EVENT_W-1:0] = fifo_dout;
          rdata_c[EV_VALID_BIT]   = 1'b1;
        end
      end
      JP_STATUS[3:2]: begin
        rdata_c[ST_COUNT_W-1:0] = ST_COUNT_W'(fifo_count);
        rdata_c[ST_EMPTY_BIT]   = fifo_empty;
        rdata_c[ST_FULL_BIT]    = fifo_full;
        rdata_c[ST_OVF_BIT]     = ovf_q;
      end
      default:        rdata_c[CTRL_IEN_BIT] = ien_q;
    endcase
  end

  assign bus.rdata = rdata_c;
  assign bus.irq   = irq_q;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr[1:0], bus.wdata[JP_DATA_W-1:ST_OVF_BIT+1],
                             bus.wdata[ST_OVF_BIT-1:CTRL_IEN_BIT+1]};

endmodule

// File: tb/tb_joypad_events.sv
// Directed bench for joypad_events: stimulus tasks queue expected read data / irq levels,
// a negedge monitor pops and compares them.
module tb_joypad_events;
  import joypad_pkg::*;

  logic clk;
  logic rst_n;
  logic chk_irq;

  joypad_events_if bus();

  joypad_events #(
    .STABLE_COUNT (3),
    .DEPTH        (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
    bit          is_irq;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [7:0]  ovf_seq  [9] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [31:0] ovf_exp  [8] = '{32'h8000_0300, 32'h8000_0001, 32'h8000_0102, 32'h8000_0204,
                                32'h8000_0408, 32'h8000_0810, 32'h8000_1020, 32'h8000_2040};
  logic [7:0]  full_seq [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [31:0] full_exp [8] = '{32'h8000_0102, 32'h8000_0204, 32'h8000_0408, 32'h8000_0810,
                                32'h8000_1020, 32'h8000_2040, 32'h8000_4080, 32'h8000_8001};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Monitor: compare whatever the DUT presents against the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.sel && !bus.we) begin
      if (sb.size() == 0) check("unexpected_read", bus.rdata, 32'hxxxx_xxxx);
      else begin
        e = sb.pop_front();
        check(e.name, bus.rdata, e.val);
      end
    end
    if (chk_irq) begin
      if (sb.size() == 0) check("unexpected_irq_check", 32'(bus.irq), 32'hxxxx_xxxx);
      else begin
        e = sb.pop_front();
        check(e.name, 32'(bus.irq), e.val);
      end
    end
  end

  task automatic expect_val(input string nm, input logic [31:0] v, input bit is_irq);
    exp_t e;
    e.name = nm; e.val = v; e.is_irq = is_irq;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] v);
    bus.joypad_valid = 1'b1;
    bus.joypad       = v;
    step();
    bus.joypad_valid = 1'b0;
  endtask

  task automatic settle(input logic [7:0] v);
    repeat (3) sample(v);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
    expect_val(nm, exp, 1'b0);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    step();
    bus.sel = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    step();
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic irq_is(input bit v, input string nm);
    expect_val(nm, 32'(v), 1'b1);
    chk_irq = 1'b1;
    step();
    chk_irq = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; chk_irq = 1'b0;
    bus.joypad_valid = 1'b0; bus.joypad = '0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (2) step();
    rst_n = 1'b1;

    // Reset state
    rd(JP_STATE,  32'h0000_0000, "rst_state");
    rd(JP_EVENT,  32'h0000_0000, "rst_event");
    rd(JP_STATUS, 32'h0000_0100, "rst_status");
    rd(JP_CTRL,   32'h0000_0000, "rst_ctrl");
    irq_is(1'b0, "rst_irq");

    // Debounce: 01 01 02 01 01 01 only takes effect on the last sample
    sample(8'h01); rd(JP_STATE, 32'h0, "db_s1");
    sample(8'h01); rd(JP_STATE, 32'h0, "db_s2");
    sample(8'h02); rd(JP_STATE, 32'h0, "db_s3");
    sample(8'h01); rd(JP_STATE, 32'h0, "db_s4");
    sample(8'h01); rd(JP_STATE, 32'h0, "db_s5");
    sample(8'h01); rd(JP_STATE, 32'h0000_0001, "db_s6");
    rd(JP_STATUS, 32'h0000_0001, "db_status");
    rd(JP_EVENT,  32'h8000_0001, "db_event");
    rd(JP_EVENT,  32'h0000_0000, "db_event_empty");

    // Press and release in one change
    settle(8'h81);
    rd(JP_EVENT, 32'h8000_0080, "pr_to81");
    settle(8'h03);
    rd(JP_EVENT, 32'h8000_8002, "pr_to03");
    rd(JP_STATE, 32'h0000_0003, "pr_state");

    // Overflow: nine changes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) settle(ovf_seq[i]);
    rd(JP_STATUS, 32'h0001_0208, "ovf_status");
    rd(JP_STATE,  32'h0000_0080, "ovf_state");
    for (int i = 0; i < 8; i++) rd(JP_EVENT, ovf_exp[i], $sformatf("ovf_ev%0d", i));
    rd(JP_STATUS, 32'h0001_0100, "ovf_drained");
    wr(JP_STATUS, 32'h0001_0000);
    rd(JP_STATUS, 32'h0000_0100, "ovf_w1c");

    // Full FIFO: EVENT read coincides with the push of a ninth event
    for (int i = 0; i < 8; i++) settle(full_seq[i]);
    rd(JP_STATUS, 32'h0000_0208, "full_status");
    sample(8'h01);
    sample(8'h01);
    expect_val("full_pushpop_head", 32'h8000_8001, 1'b0);
    bus.joypad_valid = 1'b1; bus.joypad = 8'h01;
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = JP_EVENT;
    step();
    bus.joypad_valid = 1'b0; bus.sel = 1'b0;
    rd(JP_STATUS, 32'h0000_0208, "full_pushpop_status");
    for (int i = 0; i < 8; i++) rd(JP_EVENT, full_exp[i], $sformatf("full_ev%0d", i));
    rd(JP_STATUS, 32'h0000_0100, "full_drained");

    // IRQ disabled: an event never raises irq
    settle(8'h02);
    irq_is(1'b0, "irq_off_a");
    irq_is(1'b0, "irq_off_b");
    rd(JP_EVENT, 32'h8000_0102, "irq_off_event");

    // IRQ enabled: one-cycle lag on rise and fall
    wr(JP_CTRL, 32'h0000_0001);
    rd(JP_CTRL, 32'h0000_0001, "ctrl_ien");
    settle(8'h04);
    irq_is(1'b0, "irq_lag");
    irq_is(1'b1, "irq_rise");
    rd(JP_EVENT, 32'h8000_0204, "irq_event");
    irq_is(1'b1, "irq_hold");
    irq_is(1'b0, "irq_fall");

    // Reset with three events queued, a primed sample and a bus write in the reset cycle
    settle(8'h08);
    settle(8'h10);
    settle(8'h20);
    irq_is(1'b1, "pre_rst_irq");
    rd(JP_STATUS, 32'h0000_0003, "pre_rst_status");
    sample(8'h40);
    sample(8'h40);
    rst_n = 1'b0;
    bus.joypad_valid = 1'b1; bus.joypad = 8'h40;
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = JP_CTRL; bus.wdata = 32'h0000_0001;
    step();
    rst_n = 1'b1;
    bus.joypad_valid = 1'b0; bus.sel = 1'b0; bus.we = 1'b0;
    irq_is(1'b0, "mid_rst_irq");
    rd(JP_STATE,  32'h0000_0000, "mid_rst_state");
    rd(JP_EVENT,  32'h0000_0000, "mid_rst_event");
    rd(JP_STATUS, 32'h0000_0100, "mid_rst_status");
    rd(JP_CTRL,   32'h0000_0000, "mid_rst_ctrl");

    repeat (3) step();
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
